// File: rtl/sram_pkg.sv
// Shared array geometry, FSM state encoding and small constant helpers for the
// SRAM serial controller.
package sram_pkg;

    localparam int ROWS = 16;
    localparam int COLS = 8;
    localparam int AW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BCW  = $clog2(COLS + 1);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WR_WL,
        RD_WL,
        RD_SAE
    } sram_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sram_deserializer.sv
// MSB-first serial word capture: a strobe divider, a COLS-bit shift register
// and a saturating bit counter that the controller clears on write accept.
module sram_deserializer
    import sram_pkg::*;
#(
    parameter int SHIFT_DIV = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            serial_in,
    input  logic            shift,
    input  logic            clr,
    output logic [COLS-1:0] word,
    output logic            word_full,
    output logic [BCW-1:0]  bitcnt
);

    localparam int DIVW = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SHIFT_DIV - 1);
    localparam logic [BCW-1:0]  CNT_FULL = BCW'(COLS);

    logic [DIVW-1:0] div_q, div_d;
    logic [COLS-1:0] sreg_q, sreg_d;
    logic [BCW-1:0]  bitcnt_q, bitcnt_d;
    logic            bit_tick;

    assign bit_tick = shift && (div_q == DIV_LAST);

    always_comb begin
        div_d    = div_q;
        sreg_d   = sreg_q;
        bitcnt_d = bitcnt_q;

        if (!shift || bit_tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIVW'(1);
        end

        // Extra bits keep shifting so the most recent COLS bits form the word.
        if (bit_tick) begin
            sreg_d = {sreg_q[COLS-2:0], serial_in};
            if (bitcnt_q != CNT_FULL) begin
                bitcnt_d = bitcnt_q + BCW'(1);
            end
        end

        if (clr) begin
            bitcnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            sreg_q   <= '0;
            bitcnt_q <= '0;
        end else begin
            div_q    <= div_d;
            sreg_q   <= sreg_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    assign word      = sreg_q;
    assign word_full = (bitcnt_q == CNT_FULL);
    assign bitcnt    = bitcnt_q;

endmodule

// File: rtl/sram_serial_ctrl.sv
// Device-side SRAM command responder: accepts w_en/r_en in IDLE and sequences
// precharge, wordline, write-driver and sense-amp controls for the array macro.
//
// Handshake: w_en/r_en are single-cycle requests honoured only when the FSM is
// in IDLE; any request that cannot be honoured is dropped and reported with a
// one-cycle cmd_err pulse. Read completion is the one-cycle data_valid pulse.
module sram_serial_ctrl
    import sram_pkg::*;
#(
    parameter int SHIFT_DIV = 2,
    parameter int PRE_CYC   = 2,
    parameter int WL_CYC    = 2,
    parameter int SAE_CYC   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            serial_in,
    input  logic            shift,
    input  logic            w_en,
    input  logic            r_en,
    input  logic [AW-1:0]   addr,
    output logic            data_valid,
    output logic [COLS-1:0] data_out,
    output logic            busy,
    output logic            cmd_err,
    output logic            pre_en,
    output logic            wl_en,
    output logic [AW-1:0]   wl_addr,
    output logic            wr_drv_en,
    output logic [COLS-1:0] bl_wdata,
    output logic            sae,
    input  logic [COLS-1:0] sa_rdata,
    output sram_state_t     dbg_state,
    output logic [BCW-1:0]  dbg_bitcnt,
    output logic            dbg_word_full
);

    localparam int CYCW = $clog2(max3(PRE_CYC, WL_CYC, SAE_CYC) + 1);
    localparam logic [CYCW-1:0] PRE_LD = CYCW'(PRE_CYC - 1);
    localparam logic [CYCW-1:0] WL_LD  = CYCW'(WL_CYC - 1);
    localparam logic [CYCW-1:0] SAE_LD = CYCW'(SAE_CYC - 1);
    localparam bit ROWS_POW2 = (ROWS == (1 << AW));

    sram_state_t     state_q, state_d;
    logic [CYCW-1:0] cnt_q, cnt_d;
    logic            is_wr_q, is_wr_d;
    logic            busy_q, busy_d;
    logic            cmd_err_q, cmd_err_d;
    logic            data_valid_q, data_valid_d;
    logic [COLS-1:0] data_out_q, data_out_d;
    logic [AW-1:0]   wl_addr_q, wl_addr_d;
    logic [COLS-1:0] bl_wdata_q, bl_wdata_d;
    logic            pre_en_q, pre_en_d;
    logic            wl_en_q, wl_en_d;
    logic            wr_drv_en_q, wr_drv_en_d;
    logic            sae_q, sae_d;

    logic [COLS-1:0] word;
    logic            word_full;
    logic [BCW-1:0]  bitcnt;
    logic            wr_clr;
    logic            addr_bad;
    logic            cnt_done;

    sram_deserializer #(
        .SHIFT_DIV (SHIFT_DIV)
    ) u_deser (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .shift     (shift),
        .clr       (wr_clr),
        .word      (word),
        .word_full (word_full),
        .bitcnt    (bitcnt)
    );

    // Only reachable when ROWS leaves unused codes in the address field.
    assign addr_bad = !ROWS_POW2 && (int'(addr) >= ROWS);
    assign cnt_done = (cnt_q == '0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_wr_d      = is_wr_q;
        busy_d       = busy_q;
        cmd_err_d    = 1'b0;
        data_valid_d = 1'b0;
        data_out_d   = data_out_q;
        wl_addr_d    = wl_addr_q;
        bl_wdata_d   = bl_wdata_q;
        wr_clr       = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_en || r_en) begin
                    if (addr_bad) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        state_d   = PRE;
                        cnt_d     = PRE_LD;
                        busy_d    = 1'b1;
                        wl_addr_d = addr;
                        is_wr_d   = w_en;
                        if (w_en) begin
                            bl_wdata_d = word;
                            wr_clr     = 1'b1;
                            cmd_err_d  = r_en;
                        end
                    end
                end
            end
            PRE: begin
                if (cnt_done) begin
                    state_d = is_wr_q ? WR_WL : RD_WL;
                    cnt_d   = WL_LD;
                end else begin
                    cnt_d = cnt_q - CYCW'(1);
                end
            end
            WR_WL: begin
                if (cnt_done) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CYCW'(1);
                end
            end
            RD_WL: begin
                if (cnt_done) begin
                    state_d = RD_SAE;
                    cnt_d   = SAE_LD;
                end else begin
                    cnt_d = cnt_q - CYCW'(1);
                end
            end
            RD_SAE: begin
                if (cnt_done) begin
                    state_d      = IDLE;
                    busy_d       = 1'b0;
                    data_out_d   = sa_rdata;
                    data_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CYCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (state_q != IDLE && (w_en || r_en)) begin
            cmd_err_d = 1'b1;
        end

        // Macro controls are decoded from the next state so they register in
        // step with it; PRE and the wordline states are mutually exclusive.
        pre_en_d    = (state_d == PRE);
        wl_en_d     = (state_d == WR_WL) || (state_d == RD_WL) || (state_d == RD_SAE);
        wr_drv_en_d = (state_d == WR_WL);
        sae_d       = (state_d == RD_SAE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            is_wr_q      <= 1'b0;
            busy_q       <= 1'b0;
            cmd_err_q    <= 1'b0;
            data_valid_q <= 1'b0;
            data_out_q   <= '0;
            wl_addr_q    <= '0;
            bl_wdata_q   <= '0;
            pre_en_q     <= 1'b0;
            wl_en_q      <= 1'b0;
            wr_drv_en_q  <= 1'b0;
            sae_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_wr_q      <= is_wr_d;
            busy_q       <= busy_d;
            cmd_err_q    <= cmd_err_d;
            data_valid_q <= data_valid_d;
            data_out_q   <= data_out_d;
            wl_addr_q    <= wl_addr_d;
            bl_wdata_q   <= bl_wdata_d;
            pre_en_q     <= pre_en_d;
            wl_en_q      <= wl_en_d;
            wr_drv_en_q  <= wr_drv_en_d;
            sae_q        <= sae_d;
        end
    end

    assign data_valid    = data_valid_q;
    assign data_out      = data_out_q;
    assign busy          = busy_q;
    assign cmd_err       = cmd_err_q;
    assign pre_en        = pre_en_q;
    assign wl_en         = wl_en_q;
    assign wl_addr       = wl_addr_q;
    assign wr_drv_en     = wr_drv_en_q;
    assign bl_wdata      = bl_wdata_q;
    assign sae           = sae_q;
    assign dbg_state     = state_q;
    assign dbg_bitcnt    = bitcnt;
    assign dbg_word_full = word_full;

endmodule

// File: tb/tb_sram_serial_ctrl.sv
// Directed bench for sram_serial_ctrl with a behavioural array behind the
// macro pins and hand-computed expected words and cycle counts.
module tb_sram_serial_ctrl;
  import sram_pkg::*;

  logic            clk = 1'b0;
  logic            rst, serial_in, shift, w_en, r_en;
  logic [AW-1:0]   addr;
  logic            data_valid, busy, cmd_err, pre_en, wl_en, wr_drv_en, sae;
  logic [COLS-1:0] data_out, bl_wdata, sa_rdata;
  logic [AW-1:0]   wl_addr;
  sram_state_t     dbg_state;
  logic [BCW-1:0]  dbg_bitcnt;
  logic            dbg_word_full;

  logic [COLS-1:0] mem [ROWS];
  logic [COLS-1:0] exp_mem [ROWS];
  int errors = 0, checks = 0;
  int cmd_err_cnt = 0, dv_cnt = 0, overlap_cnt = 0;

  // clock / reset block
  always #5 clk = ~clk;

  sram_serial_ctrl dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .shift(shift),
    .w_en(w_en), .r_en(r_en), .addr(addr),
    .data_valid(data_valid), .data_out(data_out), .busy(busy), .cmd_err(cmd_err),
    .pre_en(pre_en), .wl_en(wl_en), .wl_addr(wl_addr), .wr_drv_en(wr_drv_en),
    .bl_wdata(bl_wdata), .sae(sae), .sa_rdata(sa_rdata),
    .dbg_state(dbg_state), .dbg_bitcnt(dbg_bitcnt), .dbg_word_full(dbg_word_full)
  );

  // behavioural array macro
  assign sa_rdata = mem[wl_addr];
  always @(posedge clk) if (wr_drv_en) mem[wl_addr] <= bl_wdata;

  always @(negedge clk) begin
    if (cmd_err) cmd_err_cnt++;
    if (data_valid) dv_cnt++;
    if (pre_en && wl_en) overlap_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic shift_bits(input logic [15:0] v, input int n);
    logic [15:0] bits;
    bits = v;
    for (int i = n - 1; i >= 0; i--) begin
      serial_in = bits[i];
      shift = 1'b1;
      repeat (2) tick();
    end
    shift = 1'b0;
    serial_in = 1'b0;
    tick();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic also_rd, input logic intrude,
                          output int busy_n, output int pre_n, output int drv_n,
                          output logic [7:0] wd, output logic addr_ok);
    w_en = 1'b1; r_en = also_rd; addr = a;
    tick();
    w_en = 1'b0; r_en = 1'b0;
    busy_n = 0; pre_n = 0; drv_n = 0; wd = '0; addr_ok = 1'b1;
    while (busy && busy_n < 50) begin
      busy_n++;
      if (pre_en) pre_n++;
      if (wr_drv_en) begin drv_n++; wd = bl_wdata; end
      if (wl_addr !== a) addr_ok = 1'b0;
      if (intrude && busy_n == 1) begin r_en = 1'b1; addr = a + 1'b1; end
      else begin r_en = 1'b0; addr = a; end
      tick();
    end
    r_en = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output int dv_at, output int dv_n,
                         output logic [7:0] dout, output logic busy_acc, output logic busy_at_dv);
    r_en = 1'b1; addr = a;
    tick();
    r_en = 1'b0;
    busy_acc = busy; dv_at = 0; dv_n = 0; dout = '0; busy_at_dv = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (data_valid) begin
        dv_n++;
        if (dv_at == 0) dv_at = k;
        dout = data_out;
        busy_at_dv = busy;
      end
    end
  endtask

  initial begin
    int bn, pn, dn, dva, dvn, e0, d0;
    logic [7:0] wd, dout;
    logic aok, bacc, bdv;
    int perm [ROWS];

    for (int i = 0; i < ROWS; i++) mem[i] = '0;
    rst = 1'b1; serial_in = 1'b0; shift = 1'b0; w_en = 1'b0; r_en = 1'b0; addr = '0;
    repeat (2) tick();
    rst = 1'b0;
    check("rst busy", busy, 0);
    check("rst pre_en", pre_en, 0);
    check("rst wl_en", wl_en, 0);
    check("rst data_out", data_out, 0);
    check("rst bitcnt", dbg_bitcnt, 0);
    check("rst state", dbg_state, IDLE);

    // 1: write A5 to row 3, read it back
    shift_bits(16'h00A5, 8);
    check("t1 bitcnt full", dbg_bitcnt, 8);
    check("t1 word_full", dbg_word_full, 1);
    do_write(4'd3, 1'b0, 1'b0, bn, pn, dn, wd, aok);
    check("t1 wr busy cycles", bn, 4);
    check("t1 wr pre cycles", pn, 2);
    check("t1 wr drv cycles", dn, 2);
    check("t1 bl_wdata", wd, 8'hA5);
    check("t1 bitcnt cleared", dbg_bitcnt, 0);
    do_read(4'd3, dva, dvn, dout, bacc, bdv);
    check("t1 rd accepted", bacc, 1);
    check("t1 dv cycle", dva, 6);
    check("t1 dv pulses", dvn, 1);
    check("t1 rd data", dout, 8'hA5);
    check("t1 busy at dv", bdv, 0);
    check("t1 data held", data_out, 8'hA5);

    // 2: reset in the middle of RD_SAE
    r_en = 1'b1; addr = 4'd3;
    tick();
    r_en = 1'b0;
    repeat (4) tick();
    check("t2 in sae", sae, 1);
    d0 = dv_cnt;
    rst = 1'b1;
    tick();
    check("t2 rst sae", sae, 0);
    check("t2 rst wl_en", wl_en, 0);
    check("t2 rst busy", busy, 0);
    check("t2 rst data_out", data_out, 0);
    check("t2 rst wl_addr", wl_addr, 0);
    check("t2 rst bl_wdata", bl_wdata, 0);
    check("t2 rst state", dbg_state, IDLE);
    rst = 1'b0;
    repeat (3) tick();
    check("t2 no dv", dv_cnt - d0, 0);
    do_read(4'd3, dva, dvn, dout, bacc, bdv);
    check("t2 reread data", dout, 8'hA5);

    // 3: simultaneous w_en and r_en
    shift_bits(16'h003C, 8);
    e0 = cmd_err_cnt; d0 = dv_cnt;
    do_write(4'd5, 1'b1, 1'b0, bn, pn, dn, wd, aok);
    check("t3 wr busy cycles", bn, 4);
    check("t3 bl_wdata", wd, 8'h3C);
    check("t3 cmd_err pulses", cmd_err_cnt - e0, 1);
    check("t3 no dv", dv_cnt - d0, 0);
    do_read(4'd5, dva, dvn, dout, bacc, bdv);
    check("t3 rd data", dout, 8'h3C);

    // 4: read request while a write is busy
    shift_bits(16'h005A, 8);
    e0 = cmd_err_cnt;
    do_write(4'd7, 1'b0, 1'b1, bn, pn, dn, wd, aok);
    check("t4 wr busy cycles", bn, 4);
    check("t4 wr pre cycles", pn, 2);
    check("t4 wr drv cycles", dn, 2);
    check("t4 wl_addr stable", aok, 1);
    check("t4 cmd_err pulses", cmd_err_cnt - e0, 1);
    do_read(4'd7, dva, dvn, dout, bacc, bdv);
    check("t4 rd data", dout, 8'h5A);

    // 5: over-long serial word, then a short word
    shift_bits(16'h031E, 10);
    check("t5 bitcnt saturated", dbg_bitcnt, 8);
    do_write(4'd9, 1'b0, 1'b0, bn, pn, dn, wd, aok);
    check("t5 bl_wdata", wd, 8'h1E);
    check("t5 bitcnt cleared", dbg_bitcnt, 0);
    do_read(4'd9, dva, dvn, dout, bacc, bdv);
    check("t5 rd data", dout, 8'h1E);
    shift_bits(16'h000A, 4);
    check("t5 short bitcnt", dbg_bitcnt, 4);
    check("t5 short not full", dbg_word_full, 0);
    do_write(4'd10, 1'b0, 1'b0, bn, pn, dn, wd, aok);
    check("t5 short bl_wdata", wd, 8'hEA);

    // 6: fill every row, read back in shuffled order
    for (int r = 0; r < ROWS; r++) begin
      exp_mem[r] = 8'($urandom_range(0, 255));
      shift_bits({8'h00, exp_mem[r]}, 8);
      do_write(AW'(r), 1'b0, 1'b0, bn, pn, dn, wd, aok);
      check("t6 bl_wdata", wd, exp_mem[r]);
    end
    for (int r = 0; r < ROWS; r++) perm[r] = r;
    for (int r = ROWS - 1; r > 0; r--) begin
      int j, t;
      j = $urandom_range(0, r);
      t = perm[r]; perm[r] = perm[j]; perm[j] = t;
    end
    for (int r = 0; r < ROWS; r++) begin
      do_read(AW'(perm[r]), dva, dvn, dout, bacc, bdv);
      check("t6 rd data", dout, exp_mem[perm[r]]);
      check("t6 dv cycle", dva, 6);
    end
    check("t6 pre/wl overlap", overlap_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
